// File: rtl/if_queue_pkg.sv
// Shared constants and entry payload type for the instruction fetch queue.
package if_queue_pkg;

  localparam int unsigned IfqDepth  = 4;
  localparam int unsigned IfqPtrW   = $clog2(IfqDepth);
  localparam int unsigned IfqCntW   = IfqPtrW + 1;
  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  // Stall vector bit positions and encodings
  localparam int unsigned StallFetch = 0;
  localparam int unsigned StallId    = 1;
  localparam int unsigned StallEx    = 2;
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;

  localparam logic [InstW-1:0] ZeroWord = '0;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
  } ifq_entry_t;

endpackage

// File: rtl/if_queue_fifo_mem.sv
// ifq_fifo_mem storage: DEPTH x WIDTH register array, one write port,
// one asynchronous read port. Pointer and count bookkeeping live in if_queue.
//   clk, rst_n   : clock, async active-low reset (clears every entry)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port
module ifq_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Write port next-state
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue between the fetch stage and ID. Buffers {pc, inst}
// pairs, presents one entry per cycle under the pipeline stall vector, inserts
// bubbles when starved or stalled from above, and requests a fetch stall when
// full. flush clears everything on the next edge.
// Optional feature macro: IFQ_BYPASS_EN (empty queue + unstalled ID forwards
// the fetched pair straight to the output registers, 1-cycle latency).
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   stall[5:0]       : bit0 fetch, bit1 ID, bit2 EX (Stop = 1)
//   flush            : discard all queued and presented instructions
//   ce, if_pc, if_inst : fetch enable and fetched pair
//   stallreq_if      : combinational fetch stall request (= full)
//   id_valid, id_pc, id_inst : registered entry presented to ID
module if_queue
  import if_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IfqDepth
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        ce,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = $bits(ifq_entry_t);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_valid_q, id_valid_d;
  ifq_entry_t      id_entry_q, id_entry_d;

  logic            full, empty, wr, pop, bypass, mem_we;
  ifq_entry_t      wr_entry, rd_entry;
  logic [EntryW-1:0] rd_data;
  logic            unused_stall;

  assign unused_stall = ^stall[5:3];

  assign full     = (cnt_q == CntW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign wr       = ce & (stall[StallFetch] == NoStop) & ~full & ~flush;
  assign pop      = ~flush & (stall[StallId] == NoStop) & ~empty;
  assign wr_entry = '{pc: if_pc, inst: if_inst};
  assign rd_entry = ifq_entry_t'(rd_data);

`ifdef IFQ_BYPASS_EN
  assign bypass = wr & empty & (stall[StallId] == NoStop);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry goes straight to the output registers, never to storage
  assign mem_we = wr & ~bypass;

  ifq_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  // Pointer / count next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (mem_we) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
      cnt_d = cnt_q + CntW'(mem_we) - CntW'(pop);
    end
  end

  // Output register next-state, in priority order
  always_comb begin
    id_valid_d = id_valid_q;
    id_entry_d = id_entry_q;
    if (flush) begin
      id_valid_d = 1'b0;
      id_entry_d = '0;
    end else if (stall[StallId] == Stop) begin
      // ID stalled while EX runs: slip a bubble; both stalled: hold
      if (stall[StallEx] == NoStop) begin
        id_valid_d = 1'b0;
        id_entry_d = '0;
      end
    end else if (!empty) begin
      id_valid_d = 1'b1;
      id_entry_d = rd_entry;
    end else if (bypass) begin
      id_valid_d = 1'b1;
      id_entry_d = wr_entry;
    end else begin
      id_valid_d = 1'b0;
      id_entry_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      id_valid_q <= 1'b0;
      id_entry_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      id_valid_q <= id_valid_d;
      id_entry_q <= id_entry_d;
    end
  end

  assign stallreq_if = full;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_entry_q.pc;
  assign id_inst     = id_entry_q.inst;

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue (default build, IFQ_BYPASS_EN undefined:
// 2-cycle push-to-present latency). Each table row drives one cycle of inputs
// and lists the outputs expected just after that cycle's rising edge.
// Instruction words are derived from the pc as 0xA000_0000 | pc.
module tb_if_queue;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks;
  int failures;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        ce;
    logic [31:0] pc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_full;
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs [NumVec];

  if_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .ce          (ce),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .stallreq_if (stallreq_if),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic [5:0] s, input logic f, input logic c,
                              input logic [31:0] pc, input logic ev,
                              input logic [31:0] epc, input logic efull);
    vec_t v;
    v.stall = s; v.flush = f; v.ce = c; v.pc = pc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_full = efull;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Compare all outputs against an expected presented entry
  task automatic check_out(input int idx, input logic ev, input logic [31:0] epc,
                           input logic efull);
    logic [31:0] einst;
    einst = ev ? inst_of(epc) : 32'h0;
    check("id_valid", idx, 32'(id_valid), 32'(ev));
    check("id_pc", idx, id_pc, ev ? epc : 32'h0);
    check("id_inst", idx, id_inst, einst);
    check("stallreq_if", idx, 32'(stallreq_if), 32'(efull));
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic c,
                       input logic [31:0] pc);
    stall   = s;
    flush   = f;
    ce      = c;
    if_pc   = pc;
    if_inst = inst_of(pc);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //          stall   fl   ce   pc      valid exp_pc  full
    vecs[0]  = mk(6'h00, 0, 1, 32'h00, 0, 32'h00, 0); // first push, bubble
    vecs[1]  = mk(6'h00, 0, 1, 32'h04, 1, 32'h00, 0);
    vecs[2]  = mk(6'h00, 0, 1, 32'h08, 1, 32'h04, 0);
    vecs[3]  = mk(6'h00, 0, 0, 32'h00, 1, 32'h08, 0);
    vecs[4]  = mk(6'h06, 0, 1, 32'h10, 1, 32'h08, 0); // ID+EX stalled: hold
    vecs[5]  = mk(6'h06, 0, 1, 32'h14, 1, 32'h08, 0);
    vecs[6]  = mk(6'h06, 0, 1, 32'h18, 1, 32'h08, 0);
    vecs[7]  = mk(6'h06, 0, 1, 32'h1C, 1, 32'h08, 1); // count reaches 4
    vecs[8]  = mk(6'h07, 0, 1, 32'h20, 1, 32'h08, 1); // held pc not pushed
    vecs[9]  = mk(6'h07, 0, 1, 32'h20, 1, 32'h08, 1);
    vecs[10] = mk(6'h01, 0, 1, 32'h20, 1, 32'h10, 0); // pop, fetch still stalled
    vecs[11] = mk(6'h00, 0, 1, 32'h20, 1, 32'h14, 0); // pc 0x20 pushed once
    vecs[12] = mk(6'h00, 0, 0, 32'h00, 1, 32'h18, 0);
    vecs[13] = mk(6'h02, 0, 0, 32'h00, 0, 32'h00, 0); // ID stall only: bubble
    vecs[14] = mk(6'h00, 0, 0, 32'h00, 1, 32'h1C, 0);
    vecs[15] = mk(6'h00, 0, 0, 32'h00, 1, 32'h20, 0);
    vecs[16] = mk(6'h00, 0, 1, 32'h30, 0, 32'h00, 0); // no duplicate 0x20
    vecs[17] = mk(6'h00, 0, 1, 32'h34, 1, 32'h30, 0);
    vecs[18] = mk(6'h06, 0, 1, 32'h38, 1, 32'h30, 0);
    vecs[19] = mk(6'h06, 0, 1, 32'h3C, 1, 32'h30, 0); // 3 entries queued
    vecs[20] = mk(6'h00, 1, 1, 32'h40, 0, 32'h00, 0); // flush + push 0x40
    vecs[21] = mk(6'h00, 0, 0, 32'h00, 0, 32'h00, 0); // queue really empty
    vecs[22] = mk(6'h00, 0, 1, 32'h44, 0, 32'h00, 0);
    vecs[23] = mk(6'h00, 0, 0, 32'h00, 1, 32'h44, 0);
    vecs[24] = mk(6'h00, 0, 0, 32'h00, 0, 32'h00, 0);

    rst_n = 1'b0;
    drive(6'h00, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_out(-1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].ce, vecs[i].pc);
      @(posedge clk);
      #1;
      check_out(i, vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_full);
    end

    // Fill to full behind a presented entry, then async reset mid-cycle
    @(negedge clk); drive(6'h00, 1'b0, 1'b1, 32'h50);
    @(posedge clk); #1; check_out(100, 1'b0, 32'h0, 1'b0);
    @(negedge clk); drive(6'h00, 1'b0, 1'b1, 32'h54);
    @(posedge clk); #1; check_out(101, 1'b1, 32'h50, 1'b0);
    @(negedge clk); drive(6'h06, 1'b0, 1'b1, 32'h58);
    @(posedge clk);
    @(negedge clk); drive(6'h06, 1'b0, 1'b1, 32'h5C);
    @(posedge clk);
    @(negedge clk); drive(6'h06, 1'b0, 1'b1, 32'h60);
    @(posedge clk); #1; check_out(102, 1'b1, 32'h50, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out(103, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'h00, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1; check_out(104, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1; check_out(105, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_queue.md
# if_queue

Instruction fetch queue between the PC/instruction-ROM fetch stage and the ID stage. Captures each fetched {pc, inst} pair into a small FIFO, presents one entry per cycle to ID under the pipeline `stall` vector, inserts bubbles when ID is starved or stalled from above, and requests a fetch stall when full. Clears completely on `flush` (branch redirect / exception).

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `stall`  in  6  pipeline stall vector from ctrl; bit 0 = fetch, bit 1 = ID, bit 2 = EX.
- `flush`  in  1  discard all queued and presented instructions.
- `ce`  in  1  fetch chip enable from the PC stage.
- `if_pc`  in  32  address of fetched instruction (`InstAddrBus).
- `if_inst`  in  32  fetched instruction word (`InstBus).
- `stallreq_if`  out  1  fetch stall request to ctrl; combinational, = full.
- `id_valid`  out  1  presented entry is a real instruction.
- `id_pc`  out  32  registered PC to ID.
- `id_inst`  out  32  registered instruction to ID.

## Operation
- Push enable `wr = ce & (stall[0]==NoStop) & ~full & ~flush`. A held PC is never pushed twice because full drives `stallreq_if` → `stall[0]`.
- Output update, priority order each edge:
  1. `flush`: count, read/write pointers → 0; `id_valid`/`id_pc`/`id_inst` → 0. Same-cycle push discarded.
  2. `stall[1]==Stop & stall[2]==NoStop`: bubble (outputs → 0); no pop.
  3. `stall[1]==Stop & stall[2]==Stop`: outputs hold; no pop.
  4. `stall[1]==NoStop`, queue non-empty: pop head to outputs, `id_valid`=1.
  5. `stall[1]==NoStop`, queue empty: bypass (see Configuration) or bubble.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are `$clog2(DEPTH)` bits, wrap naturally; count is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
- `full` = count==DEPTH; `empty` = count==0.
- Reset (async assert): all state and outputs 0; `stallreq_if`=0. Reset mid-fill drops all entries; no partial state survives.

## Timing
- Without bypass: push in cycle N → stored at end of N → popped at end of N+1 → on `id_*` in cycle N+2.
- With bypass, empty queue, ID not stalled: push in N → on `id_*` in N+1; entry not written to storage.
- `stallreq_if` asserts in the same cycle count reaches DEPTH; deasserts the cycle after the first pop.
- Sustained throughput: 1 instruction/cycle when ID never stalls.
- `flush` takes effect on the next edge; the first post-flush push is accepted in the cycle after flush.

## Configuration
- `IFQ_BYPASS_EN` defined: when empty and `stall[1]==NoStop` and `wr`, `if_pc`/`if_inst` load outputs directly (1-cycle latency).
- Not defined: empty and unstalled always produces a bubble; all instructions pass through storage (2-cycle latency); no combinational path from `if_*` to output-register D inputs beyond the storage mux.

## Structure
- Constants in `defines.v`: `IfqDepth` (4), `IfqPtrBus`, `IfqCntBus`; reuse `InstAddrBus`, `InstBus`, `Stop`, `NoStop`, `RstEnable`, `ZeroWord`.
- One sub-module: `ifq_fifo_mem` — DEPTH×64-bit register array, one write port, one asynchronous read port; pointer/count/output logic stays in `if_queue`.

## Test plan
- Reset then `ce`=1, no stalls, pc 0x0,0x4,0x8 → `id_pc` 0x0,0x4,0x8 consecutive from cycle 2 (cycle 1 with bypass); `id_valid`=1.
- `stall[1]`=`stall[2]`=Stop for 6 cycles with DEPTH=4 → after 4 pushes `stallreq_if`=1, `id_*` held; release → 4 entries drain in order, `stallreq_if` drops one cycle after first pop.
- `stall[1]`=Stop, `stall[2]`=NoStop for 1 cycle → `id_valid`=0, `id_inst`=0x0 that cycle, next pop resumes with the unpopped entry.
- Queue holding 3 entries, `flush`=1 with simultaneous push of pc 0x40 → next cycle count=0, outputs 0; pc 0x40 never appears.
- Full queue, one pop and `stall[0]` still asserted → count 3, no duplicate of held pc.
- Assert `rst_n`=0 asynchronously mid-cycle with 2 entries → outputs 0 immediately, queue empty after release.
